// File: rtl/ethsniff_pkg.sv
// Shared types for the string loader / comparator pair.
`timescale 1ns/1ps
package ethsniff_pkg;
    localparam int MAX_STR_LEN    = 17;
    localparam int STRLEN_W       = 5;
    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = DATA_W / 8;

    typedef logic [0:MAX_STR_LEN-1][7:0] flag_str_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_COLLECT,
        LD_COMMIT
    } loader_state_t;

    // Header length is usable only if it names 1..MAX_STR_LEN bytes.
    function automatic logic len_ok(input logic [STRLEN_W-1:0] len);
        return (len != '0) && (len <= STRLEN_W'(MAX_STR_LEN));
    endfunction

    // Number of data words carrying len bytes: ceil(len/4).
    function automatic logic [2:0] words_for_len(input logic [STRLEN_W-1:0] len);
        logic [5:0] t;
        t = {1'b0, len} + 6'd3;
        return t[4:2];
    endfunction
endpackage

// File: rtl/flagged_string_loader_if.sv
// Atom-side programming stream: valid/ready word channel plus load abort.
`timescale 1ns/1ps
interface flagged_string_loader_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              abort;

    modport master (output in_valid, output in_data, output abort, input in_ready);
    modport slave  (input in_valid, input in_data, input abort, output in_ready);
endinterface

// File: rtl/flagged_string_loader.sv
// Assembles a flagged string from header + data words in a shadow buffer and
// commits it atomically to the comparator-facing registers.
`timescale 1ns/1ps
module flagged_string_loader
    import ethsniff_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    flagged_string_loader_if.slave  s_in,
    output flag_str_t               o_flagged_string,
    output logic [STRLEN_W-1:0]     o_strlen,
    output logic                    o_string_valid,
    output logic                    o_cmp_clear,
    output logic                    o_load_done,
    output logic                    o_load_err,
    output logic                    o_busy
);

    loader_state_t          r_state, w_next;
    flag_str_t              r_shadow;
    logic [STRLEN_W-1:0]    r_len;
    logic [2:0]             r_word_cnt;
    logic [4:0]             r_byte_ptr;

    logic                   w_ready;
    logic                   w_xfer;
    logic [STRLEN_W-1:0]    w_hdr_len;
    logic                   w_hdr_ok;
    logic [5:0]             w_idx [BYTES_PER_WORD];
    logic [BYTES_PER_WORD-1:0] w_wen;

    assign w_hdr_len     = s_in.in_data[STRLEN_W-1:0];
    assign w_hdr_ok      = len_ok(w_hdr_len);
    assign w_xfer        = s_in.in_valid & w_ready;
    assign s_in.in_ready = w_ready;
    assign o_busy        = (r_state != LD_IDLE);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= LD_IDLE;
        else        r_state <= w_next;
    end

    // Next state and ready; abort in COLLECT blocks the word so it is never consumed.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            LD_IDLE: begin
                w_ready = 1'b1;
                if (s_in.in_valid && w_hdr_ok) w_next = LD_COLLECT;
            end
            LD_COLLECT: begin
                w_ready = !s_in.abort;
                if (s_in.abort)                                w_next = LD_IDLE;
                else if (s_in.in_valid && r_word_cnt == 3'd1)  w_next = LD_COMMIT;
            end
            LD_COMMIT: w_next = LD_IDLE;
            default:   w_next = LD_IDLE;
        endcase
    end

    // Destination index for each byte lane: char k lands at 17-len+k; lanes past len are dropped.
    always_comb begin
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            w_idx[b] = 6'(MAX_STR_LEN) - {1'b0, r_len} + {1'b0, r_byte_ptr} + 6'(b);
            w_wen[b] = ({1'b0, r_byte_ptr} + 6'(b)) < {1'b0, r_len};
        end
    end

    // Shadow buffer and frame counters; header clears shadow so leading bytes read zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shadow   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_ptr <= '0;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (w_xfer && w_hdr_ok) begin
                        r_shadow   <= '0;
                        r_len      <= w_hdr_len;
                        r_word_cnt <= words_for_len(w_hdr_len);
                        r_byte_ptr <= '0;
                    end
                end
                LD_COLLECT: begin
                    if (s_in.abort) begin
                        r_shadow   <= '0;
                        r_word_cnt <= '0;
                        r_byte_ptr <= '0;
                    end else if (w_xfer) begin
                        for (int i = 0; i < MAX_STR_LEN; i++)
                            for (int b = 0; b < BYTES_PER_WORD; b++)
                                if (w_wen[b] && w_idx[b] == 6'(i))
                                    r_shadow[i] <= s_in.in_data[8*b +: 8];
                        r_word_cnt <= r_word_cnt - 3'd1;
                        r_byte_ptr <= r_byte_ptr + 5'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Committed outputs and one-cycle status pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_flagged_string <= '0;
            o_strlen         <= '0;
            o_string_valid   <= 1'b0;
            o_cmp_clear      <= 1'b0;
            o_load_done      <= 1'b0;
            o_load_err       <= 1'b0;
        end else begin
            o_cmp_clear <= 1'b0;
            o_load_done <= 1'b0;
            o_load_err  <= (r_state == LD_IDLE) && w_xfer && !w_hdr_ok;
            if (r_state == LD_COMMIT) begin
                o_flagged_string <= r_shadow;
                o_strlen         <= r_len;
                o_string_valid   <= 1'b1;
                o_cmp_clear      <= 1'b1;
                o_load_done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flagged_string_loader.sv
// Directed bench for flagged_string_loader with a commit scoreboard.
`timescale 1ns/1ps
module tb_flagged_string_loader;
    import ethsniff_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    flagged_string_loader_if #(.DATA_W(32)) bus();

    flag_str_t   fs;
    logic [4:0]  sl;
    logic        sv, cc, ld, le, bsy;

    flagged_string_loader dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .s_in             (bus),
        .o_flagged_string (fs),
        .o_strlen         (sl),
        .o_string_valid   (sv),
        .o_cmp_clear      (cc),
        .o_load_done      (ld),
        .o_load_err       (le),
        .o_busy           (bsy)
    );

    typedef struct {
        flag_str_t  str;
        logic [4:0] len;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  chars [17];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every load_done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst === 1'b1 && ld === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_done", ld, 1'b0);
            else begin
                e = sb.pop_front();
                chk("sb_string", fs, e.str);
                chk("sb_strlen", sl, e.len);
                chk("sb_cmp_clear", cc, 1'b1);
                chk("sb_string_valid", sv, 1'b1);
            end
        end
        if (ld === 1'b1 && le === 1'b1) chk("pulse_overlap", le, 1'b0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic flag_str_t model(input int len);
        flag_str_t r;
        r = '0;
        for (int k = 0; k < len; k++) r[17 - len + k] = chars[k];
        return r;
    endfunction

    // One handshake transfer: present word from a negedge, hold until accepted.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        #1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (bus.in_ready !== 1'b1) chk("ready_timeout", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Full frame from chars[]; unused byte lanes carry junk that must be ignored.
    task automatic load(input int len, input bit gaps);
        exp_t e;
        logic [31:0] w;
        e.str = model(len);
        e.len = 5'(len);
        sb.push_back(e);
        send({27'h1234567, 5'(len)});
        for (int wi = 0; wi < (len + 3) / 4; wi++) begin
            for (int b = 0; b < 4; b++)
                w[8*b +: 8] = (4*wi + b < len) ? chars[4*wi + b] : 8'hEE;
            if (gaps) begin
                @(negedge clk);
                chk("busy_in_gap", bsy, 1'b1);
            end
            send(w);
        end
    endtask

    // Pulse must appear on the second cycle after the last word and last one cycle.
    task automatic wait_done();
        int n;
        n = 0;
        while (n < 10) begin
            @(negedge clk); n++;
            if (n == 1) chk("busy_commit", bsy, 1'b1);
            if (ld === 1'b1) break;
        end
        chk("done_latency", n, 2);
        @(negedge clk);
        chk("done_width", ld, 1'b0);
        chk("cmp_clear_width", cc, 1'b0);
        chk("idle_after_commit", bsy, 1'b0);
    endtask

    initial begin
        flag_str_t  prev_fs;
        logic [4:0] prev_sl;

        n_rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.abort    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_string", fs, '0);
        chk("rst_strlen", sl, 5'd0);
        chk("rst_valid", sv, 1'b0);
        chk("rst_pulses", {cc, ld, le}, 3'b000);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        n_rst = 1'b1;

        // 1: "abcde"
        chars[0] = 8'h61; chars[1] = 8'h62; chars[2] = 8'h63; chars[3] = 8'h64; chars[4] = 8'h65;
        load(5, 1'b0);
        wait_done();
        chk("t1_strlen", sl, 5'd5);
        chk("t1_tail", fs[12:16], 40'h6162636465);
        chk("t1_lead", fs[0:11], '0);
        chk("t1_valid", sv, 1'b1);

        // 2: full length, stalled stream
        for (int k = 0; k < 17; k++) chars[k] = 8'h30 + 8'(k);
        load(17, 1'b1);
        wait_done();
        chk("t2_first", fs[0], 8'h30);
        chk("t2_last", fs[16], 8'h40);
        chk("t2_strlen", sl, 5'd17);

        // 3: rejected headers
        prev_fs = fs; prev_sl = sl;
        send(32'h0000_0000);
        @(negedge clk);
        chk("t3_err0", le, 1'b1);
        chk("t3_idle0", bsy, 1'b0);
        @(negedge clk);
        chk("t3_err0_width", le, 1'b0);
        send(32'hFFFF_FF12);
        @(negedge clk);
        chk("t3_err18", le, 1'b1);
        chk("t3_idle18", bsy, 1'b0);
        @(negedge clk);
        chk("t3_err18_width", le, 1'b0);
        chk("t3_strlen", sl, prev_sl);
        chk("t3_string", fs, prev_fs);
        chk("t3_valid", sv, 1'b1);

        // 4: abort mid-collect
        send({27'd0, 5'd8});
        send(32'h4443_4241);
        @(negedge clk);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h4847_4645;
        #1;
        chk("t4_ready_low", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle", bsy, 1'b0);
        chk("t4_no_done", ld, 1'b0);
        chk("t4_string", fs, prev_fs);
        chk("t4_strlen", sl, prev_sl);
        for (int k = 0; k < 8; k++) chars[k] = 8'h61 + 8'(k);
        load(8, 1'b0);
        wait_done();
        chk("t4_reload_len", sl, 5'd8);

        // 5: long then short, no stale bytes
        for (int k = 0; k < 17; k++) chars[k] = 8'h41;
        load(17, 1'b0);
        wait_done();
        chars[0] = 8'h78; chars[1] = 8'h79; chars[2] = 8'h7A;
        load(3, 1'b0);
        wait_done();
        chk("t5_strlen", sl, 5'd3);
        chk("t5_tail", fs[14:16], 24'h78797A);
        chk("t5_lead", fs[0:13], '0);

        // 6: async reset during collect
        send({27'd0, 5'd8});
        send(32'h3231_3039);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_string", fs, '0);
        chk("t6_strlen", sl, 5'd0);
        chk("t6_valid", sv, 1'b0);
        chk("t6_busy", bsy, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        chars[0] = 8'h51; chars[1] = 8'h52; chars[2] = 8'h53; chars[3] = 8'h54;
        load(4, 1'b0);
        wait_done();
        chk("t6_reload_len", sl, 5'd4);
        chk("t6_reload_str", fs[13:16], 32'h51525354);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
